// File: rtl/sha256_msg_ctrl_pkg.sv
// Shared types and constants for the SHA-256 multi-block message sequencer.
package sha256_pkg;

    typedef logic [511:0] block_t;
    typedef logic [255:0] digest_t;

    localparam digest_t SHA256_IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } ctrl_state_t;

endpackage

// File: rtl/sha256_msg_ctrl_if.sv
// Block stream, core and digest handshake signals of the SHA-256 message sequencer.
// The master modport is the controller's view; slave is the surrounding system's view.
interface sha256_msg_ctrl_if #(
    parameter int MAX_BLOCKS = 1024
);
    import sha256_pkg::*;

    localparam int CNT_W = $clog2(MAX_BLOCKS + 1);

    logic             blk_valid;
    logic             blk_ready;
    block_t           blk_data;
    logic             blk_last;
    digest_t          core_H_in;
    block_t           core_M_in;
    logic             core_input_valid;
    digest_t          core_H_out;
    logic             core_output_valid;
    digest_t          digest;
    logic             digest_valid;
    logic             digest_ready;
    logic             busy;
    logic [CNT_W-1:0] block_cnt;
    logic             err;

    modport master (
        input  blk_valid, blk_data, blk_last, core_H_out, core_output_valid, digest_ready,
        output blk_ready, core_H_in, core_M_in, core_input_valid, digest, digest_valid,
               busy, block_cnt, err
    );

    modport slave (
        output blk_valid, blk_data, blk_last, core_H_out, core_output_valid, digest_ready,
        input  blk_ready, core_H_in, core_M_in, core_input_valid, digest, digest_valid,
               busy, block_cnt, err
    );

endinterface

// File: rtl/sha256_msg_ctrl.sv
// Sequences pre-padded 512-bit blocks through one sha256_block core, chaining H between blocks.
// Optional core-latency watchdog: define SHA256_MSG_CTRL_TIMEOUT_EN.
module sha256_msg_ctrl
    import sha256_pkg::*;
#(
    parameter int MAX_BLOCKS     = 1024,
    parameter int TIMEOUT_CYCLES = 128
) (
    input logic             clk,
    input logic             rst_n,
    sha256_msg_ctrl_if.master bus
);

    localparam int CNT_W = $clog2(MAX_BLOCKS + 1);

    if (MAX_BLOCKS < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("sha256_msg_ctrl: MAX_BLOCKS and TIMEOUT_CYCLES must be at least 1");
    end

    ctrl_state_t      state;
    digest_t          h_reg;
    block_t           m_reg;
    logic             last_reg;
    logic             blk_ready;
    logic             core_input_valid;
    logic             digest_valid;
    digest_t          digest;
    logic [CNT_W-1:0] block_cnt;
    logic             err;

`ifdef SHA256_MSG_CTRL_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WAIT_W-1:0] wait_cnt;
`endif

    // In WAIT, blk_ready high marks the mid-message accept phase: the core is idle and
    // H_reg holds the chaining value until the source supplies the next block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            h_reg            <= SHA256_IV;
            m_reg            <= '0;
            last_reg         <= 1'b0;
            blk_ready        <= 1'b0;
            core_input_valid <= 1'b0;
            digest_valid     <= 1'b0;
            digest           <= '0;
            block_cnt        <= '0;
            err              <= 1'b0;
`ifdef SHA256_MSG_CTRL_TIMEOUT_EN
            wait_cnt         <= '0;
`endif
        end else begin
            core_input_valid <= 1'b0;
            case (state)
                IDLE: begin
                    blk_ready <= 1'b1;
                    if (bus.blk_valid && blk_ready) begin
                        m_reg            <= bus.blk_data;
                        last_reg         <= bus.blk_last;
                        h_reg            <= SHA256_IV;
                        block_cnt        <= '0;
                        err              <= 1'b0;
                        blk_ready        <= 1'b0;
                        core_input_valid <= 1'b1;
                        state            <= ISSUE;
                    end
                    if (bus.core_output_valid) begin
                        err <= 1'b1;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
`ifdef SHA256_MSG_CTRL_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    if (bus.core_output_valid) begin
                        err <= 1'b1;
                    end
                end
                WAIT: begin
                    if (blk_ready) begin
                        if (bus.core_output_valid) begin
                            err <= 1'b1;
                        end
                        if (bus.blk_valid) begin
                            m_reg            <= bus.blk_data;
                            last_reg         <= bus.blk_last;
                            blk_ready        <= 1'b0;
                            core_input_valid <= 1'b1;
                            state            <= ISSUE;
                        end
                    end else if (bus.core_output_valid) begin
                        h_reg     <= bus.core_H_out;
                        block_cnt <= block_cnt + CNT_W'(1);
                        // Hitting MAX_BLOCKS without a last block ends the message early, flagged.
                        if (last_reg || block_cnt == CNT_W'(MAX_BLOCKS - 1)) begin
                            digest       <= bus.core_H_out;
                            digest_valid <= 1'b1;
                            state        <= DONE;
                            if (!last_reg) begin
                                err <= 1'b1;
                            end
                        end else begin
                            blk_ready <= 1'b1;
                        end
                    end
`ifdef SHA256_MSG_CTRL_TIMEOUT_EN
                    else if (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                        err          <= 1'b1;
                        digest       <= '0;
                        digest_valid <= 1'b1;
                        state        <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
`endif
                end
                DONE: begin
                    if (bus.core_output_valid) begin
                        err <= 1'b1;
                    end
                    if (bus.digest_ready) begin
                        digest_valid <= 1'b0;
                        blk_ready    <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.blk_ready        = blk_ready;
    assign bus.core_H_in        = h_reg;
    assign bus.core_M_in        = m_reg;
    assign bus.core_input_valid = core_input_valid;
    assign bus.digest           = digest;
    assign bus.digest_valid     = digest_valid;
    assign bus.busy             = (state != IDLE);
    assign bus.block_cnt        = block_cnt;
    assign bus.err              = err;

endmodule
